// File: rtl/hex_display_pkg.sv
// Shared constants and helpers for the hex seven-segment display controller.
package hex_display_pkg;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Counter/index width: ceil(log2(n)) but never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Active-low gfedcba pattern for one hex nibble (bit0 = a, bit6 = g).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_scan_timer.sv
// Scan timing for the multiplexed display: prescaler, digit index and blink phase.
// A tick is the last prescaler cycle of a scan slot; the index and the blink
// tick counter both advance on the edge that ends that cycle.
module hex_scan_timer
    import hex_display_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int PRESCALE    = 50000,
    parameter int BLINK_TICKS = 256,
    parameter int IDX_W       = clog2_min1(N_DIGITS)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    output logic             o_tick,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_phase
);

    localparam int PS_W = clog2_min1(PRESCALE);
    localparam int BT_W = clog2_min1(BLINK_TICKS);

    logic [PS_W-1:0] ps_cnt;
    logic [BT_W-1:0] blink_cnt;

    assign o_tick = (ps_cnt == PS_W'(PRESCALE - 1));

    // Prescaler: free-running 0..PRESCALE-1.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ps_cnt <= '0;
        end else if (o_tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    // Scan index: advances once per tick, wrapping at the last digit.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_idx <= '0;
        end else if (o_tick) begin
            if (o_idx == IDX_W'(N_DIGITS - 1)) begin
                o_idx <= '0;
            end else begin
                o_idx <= o_idx + 1'b1;
            end
        end
    end

    // Blink: count ticks and flip the phase every BLINK_TICKS ticks.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            blink_cnt <= '0;
            o_phase   <= 1'b0;
        end else if (o_tick) begin
            if (blink_cnt == BT_W'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                o_phase   <= ~o_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// N-digit hex seven-segment controller: loadable shadow value, leading-zero
// blanking, per-digit blink and decimal points, driving both a registered
// parallel segment bus and a time-multiplexed scan interface. Every output is
// taken straight from a flop so the pins never glitch.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int PRESCALE    = 50000,
    parameter int BLINK_TICKS = 256
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [4*N_DIGITS-1:0] i_data,
    input  logic                  i_load,
    input  logic                  i_blank_lz,
    input  logic [N_DIGITS-1:0]   i_blink_mask,
    input  logic [N_DIGITS-1:0]   i_dp,
    output logic [7*N_DIGITS-1:0] o_hex,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [N_DIGITS-1:0]   o_an
);

    localparam int IDX_W = clog2_min1(N_DIGITS);

    logic [4*N_DIGITS-1:0] shadow;
    logic [IDX_W-1:0]      scan_idx;
    logic                  blink_phase;
    logic [N_DIGITS-1:0]   blink_off;
    logic [N_DIGITS-1:0]   lz_blank;
    logic [7*N_DIGITS-1:0] hex_next;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [N_DIGITS-1:0]   an_next;

    // The tick is only needed inside the timer; the top works from idx/phase.
    hex_scan_timer #(
        .N_DIGITS    (N_DIGITS),
        .PRESCALE    (PRESCALE),
        .BLINK_TICKS (BLINK_TICKS),
        .IDX_W       (IDX_W)
    ) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_tick  (),
        .o_idx   (scan_idx),
        .o_phase (blink_phase)
    );

    // Shadow register: captures i_data on every cycle i_load is high.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shadow <= '0;
        end else if (i_load) begin
            shadow <= i_data;
        end
    end

    assign blink_off = {N_DIGITS{blink_phase}} & i_blink_mask;

    // Leading-zero detect: walk from the top digit down while every digit seen is zero.
    always_comb begin
        logic zero_run;
        lz_blank = '0;
        zero_run = 1'b1;
        for (int j = N_DIGITS - 1; j >= 0; j--) begin
            zero_run    = zero_run & (shadow[4*j +: 4] == 4'h0);
            lz_blank[j] = i_blank_lz & zero_run & (j != 0);
        end
    end

    // Final per-digit segments after blanking and blink masking.
    always_comb begin
        hex_next = '0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (lz_blank[j] || blink_off[j]) begin
                hex_next[7*j +: 7] = SEG_BLANK;
            end else begin
                hex_next[7*j +: 7] = hex_to_seg(shadow[4*j +: 4]);
            end
        end
    end

    // Scan mux: pick the current digit's segments, dp and anode enable.
    always_comb begin
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        an_next  = '1;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (scan_idx == IDX_W'(j)) begin
                seg_next   = hex_next[7*j +: 7];
                dp_next    = ~(i_dp[j] & ~blink_off[j]);
                an_next[j] = 1'b0;
            end
        end
    end

    // Output registers; reset puts every output into its blank/off state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_hex <= {N_DIGITS{SEG_BLANK}};
            o_seg <= SEG_BLANK;
            o_dp  <= 1'b1;
            o_an  <= '1;
        end else begin
            o_hex <= hex_next;
            o_seg <= seg_next;
            o_dp  <= dp_next;
            o_an  <= an_next;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl (4 digits, PRESCALE=4, BLINK_TICKS=2).
// The reference model works from the number of clock edges since reset:
// slot = edges / PRESCALE, phase = edges / (PRESCALE*BLINK_TICKS) mod 2.
module tb_hex_display_ctrl;

    localparam int N  = 4;
    localparam int PS = 4;
    localparam int BT = 2;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b0;
    logic [15:0]   i_data = '0;
    logic          i_load = 1'b0;
    logic          i_blank_lz = 1'b0;
    logic [3:0]    i_blink_mask = '0;
    logic [3:0]    i_dp = '0;
    logic [27:0]   o_hex;
    logic [6:0]    o_seg;
    logic          o_dp;
    logic [3:0]    o_an;

    int            total = 0;
    int            passed = 0;
    int            fail_cnt = 0;
    int            n_edges = 0;
    logic [15:0]   m_shadow = '0;

    logic [6:0]    seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex_display_ctrl #(
        .N_DIGITS    (N),
        .PRESCALE    (PS),
        .BLINK_TICKS (BT)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_data       (i_data),
        .i_load       (i_load),
        .i_blank_lz   (i_blank_lz),
        .i_blink_mask (i_blink_mask),
        .i_dp         (i_dp),
        .o_hex        (o_hex),
        .o_seg        (o_seg),
        .o_dp         (o_dp),
        .o_an         (o_an)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Displayed value of all four digits from the numeric value and display controls.
    function automatic logic [27:0] model_hex(input logic [15:0] val, input logic blz,
                                              input logic [3:0] mask, input logic ph);
        logic [27:0] r;
        logic [15:0] upper;
        r = '0;
        for (int j = 0; j < N; j++) begin
            upper = val >> (4 * j);
            if ((blz && j >= 1 && upper == 16'h0) || (ph && mask[j])) begin
                r[7*j +: 7] = 7'h7F;
            end else begin
                r[7*j +: 7] = seg_tab[upper[3:0]];
            end
        end
        return r;
    endfunction

    // One clock cycle: drive inputs, take the edge, check all outputs at the negedge.
    task automatic step(input logic ld, input logic [15:0] d, input logic blz,
                        input logic [3:0] m, input logic [3:0] dpv);
        int          np;
        int          idx;
        logic        ph;
        logic [15:0] sp;
        logic [27:0] eh;
        logic [3:0]  ean;
        logic        edp;
        i_load = ld;
        i_data = d;
        i_blank_lz = blz;
        i_blink_mask = m;
        i_dp = dpv;
        np = n_edges;
        sp = m_shadow;
        @(posedge i_clk);
        if (ld) m_shadow = d;
        n_edges++;
        @(negedge i_clk);
        idx = (np / PS) % N;
        ph  = ((np / (PS * BT)) % 2) == 1;
        eh  = model_hex(sp, blz, m, ph);
        ean = 4'hF;
        ean[idx] = 1'b0;
        edp = !(dpv[idx] && !(ph && m[idx]));
        check("o_hex", {4'h0, o_hex}, {4'h0, eh});
        check("o_seg", {25'h0, o_seg}, {25'h0, eh[7*idx +: 7]});
        check("o_an", {28'h0, o_an}, {28'h0, ean});
        check("o_dp", {31'h0, o_dp}, {31'h0, edp});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hex"}, {4'h0, o_hex}, 32'h0FFF_FFFF);
        check({tag, "_seg"}, {25'h0, o_seg}, 32'h7F);
        check({tag, "_dp"}, {31'h0, o_dp}, 32'h1);
        check({tag, "_an"}, {28'h0, o_an}, 32'hF);
    endtask

    // Assert reset (called at a negedge), verify outputs without any edge, release at a negedge.
    task automatic do_reset(input string tag);
        i_reset = 1'b0;
        i_load = 1'b0;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_outputs({tag, "_held"});
        i_reset = 1'b1;
        n_edges = 0;
        m_shadow = '0;
    endtask

    initial begin
        int guard;

        // Scenario 1: reset, then idle with leading-zero blanking on.
        @(negedge i_clk);
        do_reset("rst_init");
        step(1'b0, 16'h0, 1'b1, 4'h0, 4'h0);
        check("lz_idle_hex", {4'h0, o_hex}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        repeat (6) step(1'b0, 16'h0, 1'b1, 4'h0, 4'h0);

        // Scenario 2: 0x1234 without blanking, then a full scan cycle and wrap.
        step(1'b1, 16'h1234, 1'b0, 4'h0, 4'h0);
        step(1'b0, 16'h0, 1'b0, 4'h0, 4'h0);
        check("load1234_hex", {4'h0, o_hex}, {4'h0, 7'h79, 7'h24, 7'h30, 7'h19});
        repeat (20) step(1'b0, 16'h0, 1'b0, 4'h0, 4'h0);

        // Scenario 3: interior zero, with and without leading-zero blanking.
        step(1'b1, 16'h00A0, 1'b1, 4'h0, 4'h0);
        step(1'b0, 16'h0, 1'b1, 4'h0, 4'h0);
        check("lz_00a0_hex", {4'h0, o_hex}, {4'h0, 7'h7F, 7'h7F, 7'h08, 7'h40});
        repeat (6) step(1'b0, 16'h0, 1'b1, 4'h0, 4'h0);
        step(1'b0, 16'h0, 1'b0, 4'h0, 4'h0);
        check("nolz_00a0_hex", {4'h0, o_hex}, {4'h0, 7'h40, 7'h40, 7'h08, 7'h40});
        repeat (6) step(1'b0, 16'h0, 1'b0, 4'h0, 4'h0);

        // Scenario 4: blink digit 0 with its dp lit across several phases.
        step(1'b1, 16'hFFFF, 1'b0, 4'b0001, 4'b0001);
        repeat (40) step(1'b0, 16'h0, 1'b0, 4'b0001, 4'b0001);

        // Scenario 5: load 0x5555 while digit 2 is being scanned.
        guard = 0;
        while (!(((n_edges / PS) % N) == 2 && (n_edges % PS) == 1) && guard < 64) begin
            step(1'b0, 16'h0, 1'b0, 4'h0, 4'h0);
            guard++;
        end
        check("slot2_reached", (guard < 64) ? 32'h1 : 32'h0, 32'h1);
        step(1'b1, 16'h5555, 1'b0, 4'h0, 4'h0);
        step(1'b0, 16'h0, 1'b0, 4'h0, 4'h0);
        check("midslot_seg", {25'h0, o_seg}, 32'h12);
        check("midslot_an", {28'h0, o_an}, 32'hB);
        repeat (10) step(1'b0, 16'h0, 1'b0, 4'h0, 4'h0);

        // Scenario 6: asynchronous reset during digit 3's slot, then restart from index 0.
        step(1'b1, 16'h9876, 1'b0, 4'h0, 4'hF);
        guard = 0;
        while (!(((n_edges / PS) % N) == 3 && (n_edges % PS) == 2) && guard < 64) begin
            step(1'b0, 16'h0, 1'b0, 4'h0, 4'hF);
            guard++;
        end
        check("slot3_reached", (guard < 64) ? 32'h1 : 32'h0, 32'h1);
        check("slot3_an", {28'h0, o_an}, 32'h7);
        do_reset("rst_mid");
        repeat (4) step(1'b0, 16'h0, 1'b0, 4'h0, 4'hF);
        check("restart_an0", {28'h0, o_an}, 32'hE);
        step(1'b0, 16'h0, 1'b0, 4'h0, 4'hF);
        check("restart_an1", {28'h0, o_an}, 32'hD);
        repeat (12) step(1'b0, 16'h0, 1'b0, 4'h0, 4'hF);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), 16'($urandom), 1'($urandom),
                 4'($urandom), 4'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
